chiplib_clk_gen_ctrl: RTL and testbench

- Clock-generation stage directly upstream of the chiplib 4:1 clock-select mux.
- Derives three divided clocks from the single core clock: div2, div4 and programmable divN. They drive mux data inputs b/c/d; input a is the raw clock, wired outside this block.
- Also owns the mux select. Select changes are sequenced through a park/restart window, so the switch happens while all divided clocks are low and all clocks restart phase-aligned.

---
 rtl/chiplib_clk_pkg.sv | 28 ++
 rtl/chiplib_clk_gen_ctrl_divn.sv | 62 ++++++
 rtl/chiplib_clk_gen_ctrl.sv | 150 +++++++++++++++
 tb/tb_chiplib_clk_gen_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/chiplib_clk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chiplib_clk_pkg
// Purpose  : Shared definitions for the chiplib clock-generation stage:
//            mux select encodings, select-sequencer state type and the
//            default park length.
// Revision : 1.0 - initial release
// ============================================================================
package chiplib_clk_pkg;

    // Encodings of the downstream 4:1 clock mux select input
    localparam logic [1:0] SEL_CLK  = 2'd0;
    localparam logic [1:0] SEL_DIV2 = 2'd1;
    localparam logic [1:0] SEL_DIV4 = 2'd2;
    localparam logic [1:0] SEL_DIVN = 2'd3;

    // Default number of cycles the divided clocks are parked low
    localparam int DEF_PARK_CYC = 4;

    // Select-sequencer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PARK    = 2'd1,
        ST_RESTART = 2'd2
    } clk_state_t;

endpackage
`default_nettype wire

// File: rtl/chiplib_clk_gen_ctrl_divn.sv
`default_nettype none
// ============================================================================
// Module   : chiplib_clk_divn
// Purpose  : Programmable divide-by-N clock generator. Counter runs 0..N-1,
//            output is high while count < N/2 (floor). N is resampled from
//            ratio only at the wrap or on a restart, so a ratio change never
//            truncates the period in flight.
// Ports    : clk     - core clock
//            rst_n   - asynchronous active-low reset
//            clr     - restart: next enabled cycle begins a fresh period
//            en      - 1 = run, 0 = counter and output held at 0
//            ratio   - requested N (values below 2 behave as 2)
//            clk_out - registered divided clock
// Revision : 1.0 - initial release
// ============================================================================
module chiplib_clk_divn #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] ratio,
    output logic             clk_out
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] w_eff_n;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_wrap;
    logic             r_out;

    assign w_eff_n   = (ratio < CNT_W'(2)) ? CNT_W'(2) : ratio;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    // r_n is never below 2, so N-1 cannot underflow
    assign w_wrap    = (r_cnt == (r_n - CNT_W'(1)));

    // Output is decoded from the *next* count so the flop tracks the counter
    // with no extra cycle of lag and no combinational path to the pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_n   <= CNT_W'(2);
            r_out <= 1'b0;
        end else if (!en) begin
            r_cnt <= '0;
            r_out <= 1'b0;
        end else if (clr || w_wrap) begin
            r_cnt <= '0;
            r_n   <= w_eff_n;
            r_out <= 1'b1;
        end else begin
            r_cnt <= w_cnt_inc;
            r_out <= (w_cnt_inc < (r_n >> 1));
        end
    end

    assign clk_out = r_out;

endmodule
`default_nettype wire

// File: rtl/chiplib_clk_gen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : chiplib_clk_gen_ctrl
// Purpose  : Clock-generation stage ahead of the chiplib 4:1 clock mux.
//            Produces div2 / div4 / divN clocks and sequences mux select
//            changes through a park window (all divided clocks low, select
//            flipped mid-park) followed by a phase-aligned restart.
// Ports    : clk, rst_n            - core clock, async active-low reset
//            div_en                - run dividers (0 = outputs/counters at 0)
//            div_ratio[CNT_W]      - divN ratio (<2 behaves as 2)
//            sel_req[2],sel_req_vld- select request and one-cycle strobe
//            sel_ack               - one-cycle pulse when a switch completes
//            busy                  - switch in progress
//            mux_sel[2]            - downstream mux select
//            clk_div2/4/n          - registered divided clocks
// Options  : CHIPLIB_CLKGEN_SAME_SEL_SKIP_EN - a request equal to the current
//            mux_sel is acknowledged next cycle without parking the clocks.
// Revision : 1.0 - initial release
// ============================================================================
module chiplib_clk_gen_ctrl
    import chiplib_clk_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int PARK_CYC = DEF_PARK_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_en,
    input  logic [CNT_W-1:0] div_ratio,
    input  logic [1:0]       sel_req,
    input  logic             sel_req_vld,
    output logic             sel_ack,
    output logic             busy,
    output logic [1:0]       mux_sel,
    output logic             clk_div2,
    output logic             clk_div4,
    output logic             clk_divn
);

    localparam int           PW        = $clog2(PARK_CYC);
    localparam logic [PW-1:0] PARK_LAST = PW'(PARK_CYC - 1);
    localparam logic [PW-1:0] PARK_MID  = PW'(PARK_CYC / 2 - 1);

    clk_state_t    r_state;
    clk_state_t    w_state_nxt;
    logic [PW-1:0] r_park_cnt;
    logic [1:0]    r_sel_lat;
    logic [1:0]    r_mux_sel;
    logic          w_accept;
    logic          w_same;
    logic          r_skip_ack;

    logic          w_active;
    logic          r_run;
    logic [1:0]    r_cnt4;
    logic [1:0]    w_cnt4_nxt;
    logic          r_div2;
    logic          r_div4;

    assign w_accept = (r_state == ST_IDLE) && sel_req_vld;

`ifdef CHIPLIB_CLKGEN_SAME_SEL_SKIP_EN
    assign w_same = (sel_req == r_mux_sel);
`else
    assign w_same = 1'b0;
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept && !w_same)      w_state_nxt = ST_PARK;
            ST_PARK:    if (r_park_cnt == PARK_LAST)  w_state_nxt = ST_RESTART;
            ST_RESTART: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (r_state != ST_IDLE);
        sel_ack = (r_state == ST_RESTART) || r_skip_ack;
    end

    // Park counter, latched request and the mid-park select update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_park_cnt <= '0;
            r_sel_lat  <= SEL_CLK;
            r_mux_sel  <= SEL_CLK;
            r_skip_ack <= 1'b0;
        end else begin
            r_park_cnt <= (r_state == ST_PARK) ? r_park_cnt + PW'(1) : '0;
            if (w_accept) begin
                r_sel_lat <= sel_req;
            end
            if ((r_state == ST_PARK) && (r_park_cnt == PARK_MID)) begin
                r_mux_sel <= r_sel_lat;
            end
            r_skip_ack <= w_accept && w_same;
        end
    end

    assign mux_sel = r_mux_sel;

    // ------------------------------------------------------------ dividers
    // Clocks run only in cycles that will be IDLE; park and restart cycles
    // hold them low. r_run remembers whether the previous cycle ran, so the
    // first running cycle after any stop starts every divider at count 0
    // and all three clocks rise together.
    assign w_active   = div_en && (w_state_nxt == ST_IDLE);
    assign w_cnt4_nxt = (w_active && r_run) ? r_cnt4 + 2'd1 : 2'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run  <= 1'b0;
            r_cnt4 <= 2'd0;
            r_div2 <= 1'b0;
            r_div4 <= 1'b0;
        end else begin
            r_run  <= w_active;
            r_cnt4 <= w_cnt4_nxt;
            r_div2 <= w_active && !w_cnt4_nxt[0];
            r_div4 <= w_active && (w_cnt4_nxt < 2'd2);
        end
    end

    assign clk_div2 = r_div2;
    assign clk_div4 = r_div4;

    chiplib_clk_divn #(
        .CNT_W   (CNT_W)
    ) u_divn (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!r_run),
        .en      (w_active),
        .ratio   (div_ratio),
        .clk_out (clk_divn)
    );

endmodule
`default_nettype wire

// File: tb/tb_chiplib_clk_gen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_chiplib_clk_gen_ctrl
// Purpose  : Self-checking bench for chiplib_clk_gen_ctrl. A phase-based
//            reference model (time since restart, request edge bookkeeping)
//            predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chiplib_clk_gen_ctrl;

    localparam int CNT_W = 8;
    localparam int PARK  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             div_en;
    logic [CNT_W-1:0] div_ratio;
    logic [1:0]       sel_req;
    logic             sel_req_vld;
    logic             sel_ack;
    logic             busy;
    logic [1:0]       mux_sel;
    logic             clk_div2;
    logic             clk_div4;
    logic             clk_divn;

    always #5 clk = ~clk;

    chiplib_clk_gen_ctrl #(
        .CNT_W       (CNT_W),
        .PARK_CYC    (PARK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .div_en      (div_en),
        .div_ratio   (div_ratio),
        .sel_req     (sel_req),
        .sel_req_vld (sel_req_vld),
        .sel_ack     (sel_ack),
        .busy        (busy),
        .mux_sel     (mux_sel),
        .clk_div2    (clk_div2),
        .clk_div4    (clk_div4),
        .clk_divn    (clk_divn)
    );

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    int         ecount;      // active edges since reset
    int         m_e;         // edge at which the last switch was accepted
    int         m_k;         // cycles since clocks (re)started
    int         m_pn;        // position within current divN period
    int         m_nl;        // N of current divN period
    logic [1:0] m_mux;
    logic [1:0] m_lat;
    logic       m_busy;
    logic       m_ack;
    logic       m_act;

    function automatic int eff_n(input logic [CNT_W-1:0] r);
        return (r < 2) ? 2 : int'(r);
    endfunction

    task automatic model_reset();
        ecount = 0;  m_e = -1;   m_k = 0;  m_pn = 0; m_nl = 2;
        m_mux  = 2'd0; m_lat = 2'd0;
        m_busy = 1'b0; m_ack = 1'b0; m_act = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs sampled there
    task automatic model_step();
        logic old_busy;
        logic prev_act;
        ecount++;
        old_busy = m_busy;
        m_ack    = 1'b0;
        if (m_e >= 0 && ecount == m_e + PARK / 2) m_mux = m_lat;
        if (m_e >= 0 && ecount == m_e + PARK)     m_ack = 1'b1;
        if (!old_busy && sel_req_vld) begin
`ifdef CHIPLIB_CLKGEN_SAME_SEL_SKIP_EN
            if (sel_req == m_mux) begin
                m_ack = 1'b1;
            end else begin
                m_e   = ecount;
                m_lat = sel_req;
            end
`else
            m_e   = ecount;
            m_lat = sel_req;
`endif
        end
        m_busy   = (m_e >= 0) && (ecount >= m_e) && (ecount <= m_e + PARK);
        prev_act = m_act;
        m_act    = div_en && !m_busy;
        if (m_act) begin
            if (!prev_act) begin
                m_k = 0; m_pn = 0; m_nl = eff_n(div_ratio);
            end else begin
                m_k++;
                m_pn++;
                if (m_pn == m_nl) begin
                    m_pn = 0; m_nl = eff_n(div_ratio);
                end
            end
        end else begin
            m_k = 0; m_pn = 0;
        end
    endtask

    task automatic check1(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check1("sel_ack",  {1'b0, sel_ack},  {1'b0, m_ack});
        check1("busy",     {1'b0, busy},     {1'b0, m_busy});
        check1("mux_sel",  mux_sel,          m_mux);
        check1("clk_div2", {1'b0, clk_div2}, {1'b0, m_act && (m_k % 2 == 0)});
        check1("clk_div4", {1'b0, clk_div4}, {1'b0, m_act && (m_k % 4 < 2)});
        check1("clk_divn", {1'b0, clk_divn}, {1'b0, m_act && (m_pn < m_nl / 2)});
    endtask

    // Inputs change only at the falling edge, so the model and the DUT see
    // the same values at the rising edge; outputs are checked at the fall.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            if (rst_n) model_step();
            @(negedge clk);
            check_all();
        end
    endtask

    initial begin
        rst_n = 1'b0; div_en = 1'b0; div_ratio = 8'd6;
        sel_req = 2'd0; sel_req_vld = 1'b0;
        model_reset();
        cyc(3);

        // Free run with N = 6
        rst_n = 1'b1; div_en = 1'b1;
        cyc(24);

        // Ratio changes landing mid-period; 0 and 1 behave as 2
        div_ratio = 8'd5; cyc(20);
        div_ratio = 8'd0; cyc(10);
        div_ratio = 8'd1; cyc(10);
        div_ratio = 8'd6; cyc(5);

        // Switch to divN, with extra strobes while busy
        sel_req = 2'd3; sel_req_vld = 1'b1; cyc(1);
        sel_req_vld = 1'b0; cyc(1);
        sel_req = 2'd1; sel_req_vld = 1'b1; cyc(2);
        sel_req_vld = 1'b0; cyc(10);

        // Reset in the middle of a park window
        sel_req = 2'd2; sel_req_vld = 1'b1; cyc(1);
        sel_req_vld = 1'b0; cyc(2);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        cyc(2);
        rst_n = 1'b1;
        cyc(10);

        // div_en off and back on
        div_en = 1'b0; cyc(5);
        div_en = 1'b1; cyc(6);

        // Switch requested while dividers are stopped
        div_en = 1'b0; sel_req = 2'd1; sel_req_vld = 1'b1; cyc(1);
        sel_req_vld = 1'b0; cyc(8);
        div_en = 1'b1; cyc(6);

        // Request for the select already in use
        sel_req = m_mux; sel_req_vld = 1'b1; cyc(1);
        sel_req_vld = 1'b0; cyc(8);

        // Randomized traffic
        repeat (400) begin
            div_en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 19) == 0) div_ratio = 8'($urandom_range(0, 9));
            sel_req_vld = ($urandom_range(0, 9) == 0);
            sel_req     = 2'($urandom_range(0, 3));
            cyc(1);
        end
        sel_req_vld = 1'b0; div_en = 1'b1;
        cyc(12);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
